// File: rtl/reg8_pkg.sv
// Shared constants and state encoding for the 8x8 register file and its write loader.
package reg8_pkg;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FILL   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // A zero or over-range count means a full sweep of the register file.
    function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] c);
        return ((c == '0) || (c > CW'(DEPTH))) ? CW'(DEPTH) : c;
    endfunction

endpackage

// File: rtl/reg8file.sv
// 8x8 register file: one synchronous write port, one combinational read port.
module reg8file
    import reg8_pkg::*;
(
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] wsel,
    input  logic [DW-1:0] d,
    input  logic [AW-1:0] rsel,
    output logic [DW-1:0] q_c
);

    logic [DW-1:0] regs [DEPTH];

    // Contents deliberately survive loader resets.
    always_ff @(posedge clk) begin
        if (en) begin
            regs[wsel] <= d;
        end
    end

    assign q_c = regs[rsel];

endmodule

// File: rtl/reg8file_loader.sv
// Write sequencer for reg8file: streams handshaked bytes or a constant fill
// to auto-incrementing addresses, with a registered done pulse on the last write.
module reg8file_loader
    import reg8_pkg::*;
(
    input  logic          clk,
    input  logic          clr_n,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] base_addr,
    input  logic [CW-1:0] count,
    input  logic [DW-1:0] fill_data,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_sel,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done
);

    state_t        state, state_nx;
    logic [AW-1:0] addr, addr_nx;
    logic [CW-1:0] rem, rem_nx;
    logic [DW-1:0] fill, fill_nx;
    logic          wr_en_nx, done_nx, busy_nx;
    logic [AW-1:0] wr_sel_nx;
    logic [DW-1:0] wr_data_nx;
    logic          write_c;
    logic [DW-1:0] src_c;

    // Handshake depends on the state register only.
    assign in_ready = (state == ST_STREAM);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state   <= ST_IDLE;
            addr    <= '0;
            rem     <= '0;
            fill    <= '0;
            wr_en   <= 1'b0;
            wr_sel  <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            addr    <= addr_nx;
            rem     <= rem_nx;
            fill    <= fill_nx;
            wr_en   <= wr_en_nx;
            wr_sel  <= wr_sel_nx;
            wr_data <= wr_data_nx;
            busy    <= busy_nx;
            done    <= done_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        addr_nx    = addr;
        rem_nx     = rem;
        fill_nx    = fill;
        wr_en_nx   = 1'b0;
        wr_sel_nx  = wr_sel;
        wr_data_nx = wr_data;
        done_nx    = 1'b0;
        write_c    = 1'b0;
        src_c      = fill;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    addr_nx  = base_addr;
                    fill_nx  = fill_data;
                    rem_nx   = clamp_count(count);
                    state_nx = mode ? ST_FILL : ST_STREAM;
                end
            end
            ST_STREAM: begin
                write_c = in_valid;
                src_c   = in_data;
            end
            ST_FILL: begin
                write_c = 1'b1;
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // One write per accepted byte (or per fill cycle); the last one raises done.
        if (write_c) begin
            wr_en_nx   = 1'b1;
            wr_sel_nx  = addr;
            wr_data_nx = src_c;
            addr_nx    = addr + AW'(1);
            rem_nx     = rem - CW'(1);
            if (rem == CW'(1)) begin
                state_nx = ST_DONE;
                done_nx  = 1'b1;
            end
        end

        busy_nx = (state_nx != ST_IDLE);
    end

endmodule
